// File: rtl/nemesis_snd_out.sv
`default_nettype none
// ============================================================================
//  Module      : nemesis_snd_out
//  Description : Nemesis audio output stage. Removes the unsigned offset from
//                the mixer output, low-passes it with a first-order IIR
//                (board RC model), boxcar-decimates by DECIM and applies a
//                click-free soft mute / fade-in gain ramp.
//  Revision    : 1.0 - initial release
// ============================================================================
module nemesis_snd_out #(
  parameter int WI    = 16,
  parameter int SHIFT = 3,
  parameter int DECIM = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cen,
  input  logic [WI-1:0] i_sound,
  input  logic          i_mute,
  output logic          o_sample,
  output logic [WI-1:0] o_snd,
  output logic [7:0]    o_gain
);

  localparam int L  = $clog2(DECIM);
  localparam int SW = WI + SHIFT + 1;   // IIR state width, holds y * 2^SHIFT
  localparam int AW = WI + L;           // block accumulator width
  localparam int PW = WI + 8;           // avg x gain product width

  localparam logic [L-1:0] c_CNT_LAST = L'(DECIM - 1);
  localparam logic [7:0]   c_GAIN_MAX = 8'd128;

  logic signed [SW-1:0] r_s;
  logic signed [AW-1:0] r_acc;
  logic        [L-1:0]  r_cnt;
  logic signed [WI-1:0] r_avg;
  logic                 r_pend;
  logic                 r_sample;
  logic        [WI-1:0] r_snd;
  logic        [7:0]    r_gain;

  logic signed [WI-1:0] w_x;
  logic signed [WI-1:0] w_y;
  logic signed [SW-1:0] w_s_next;
  logic signed [AW-1:0] w_acc_sum;
  logic signed [WI-1:0] w_avg_next;
  logic                 w_wrap;
  logic signed [PW-1:0] w_avg_x;
  logic signed [PW-1:0] w_gain_x;
  logic signed [PW-1:0] w_prod;
  logic        [WI-1:0] w_snd_next;
  logic        [7:0]    w_gain_next;

  // Offset removal: flipping the MSB is the same as subtracting 0x8000.
  assign w_x = {~i_sound[WI-1], i_sound[WI-2:0]};

  // Filter output. The state is bounded to the WI-bit range scaled by
  // 2^SHIFT, so the shifted value always fits back into WI bits.
  assign w_y      = WI'(r_s >>> SHIFT);
  assign w_s_next = r_s + {{(SW-WI){w_x[WI-1]}}, w_x} - {{(SW-WI){w_y[WI-1]}}, w_y};

  // Decimator works on the pre-update filter output.
  assign w_acc_sum  = r_acc + {{L{w_y[WI-1]}}, w_y};
  assign w_avg_next = WI'(w_acc_sum >>> L);
  assign w_wrap     = i_cen && (r_cnt == c_CNT_LAST);

  // Gain is at most 128, so the 24-bit product never overflows and the
  // shifted result never exceeds the avg range.
  assign w_avg_x    = {{(PW-WI){r_avg[WI-1]}}, r_avg};
  assign w_gain_x   = {{(PW-8){1'b0}}, r_gain};
  assign w_prod     = w_avg_x * w_gain_x;
  assign w_snd_next = WI'(w_prod >>> 7);

  // Ramp one step toward the mute target; saturates at 0 and 128.
  always_comb begin
    w_gain_next = r_gain;
    if (i_mute) begin
      if (r_gain != 8'd0) w_gain_next = r_gain - 8'd1;
    end else if (r_gain < c_GAIN_MAX) begin
      w_gain_next = r_gain + 8'd1;
    end
  end

  // IIR low-pass state update on each input sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s <= '0;
    end else if (i_cen) begin
      r_s <= w_s_next;
    end
  end

  // Boxcar accumulate DECIM filter outputs and latch their floored mean.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_avg <= '0;
    end else if (i_cen) begin
      if (r_cnt == c_CNT_LAST) begin
        r_avg <= w_avg_next;
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + L'(1);
      end
    end
  end

  // Pending lasts one cycle after a block closes; that cycle emits the
  // scaled sample with the old gain and steps the gain for the next one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend   <= 1'b0;
      r_sample <= 1'b0;
      r_snd    <= '0;
      r_gain   <= 8'd0;
    end else begin
      r_pend   <= w_wrap;
      r_sample <= r_pend;
      if (r_pend) begin
        r_snd  <= w_snd_next;
        r_gain <= w_gain_next;
      end
    end
  end

  assign o_sample = r_sample;
  assign o_snd    = r_snd;
  assign o_gain   = r_gain;

endmodule
`default_nettype wire
